// File: rtl/ccmult_rr_scheduler_pkg.sv
// rtl/ccmult_rr_scheduler_pkg.sv - fixed-point widths, multiplier latency and slice helper
package ccmult_rr_scheduler_pkg;

  localparam int TOTAL_WIDTH = 16;
  localparam int FRAC_WIDTH  = 12;
  localparam int CCMULT_LAT  = 4;

  // Products only need bits up to TOTAL_WIDTH+FRAC_WIDTH-1; higher bits are discarded by truncation anyway.
  localparam int PROD_WIDTH  = TOTAL_WIDTH + FRAC_WIDTH;

  typedef logic signed [TOTAL_WIDTH-1:0] data_t;
  typedef logic signed [PROD_WIDTH-1:0]  prod_t;

  // Low bit of requester idx's operand slice in a packed per-requester bus.
  function automatic int slice_lo(input int idx);
    return idx * TOTAL_WIDTH;
  endfunction

endpackage

// File: rtl/ccmult_pipelined.sv
// rtl/ccmult_pipelined.sv - 4-stage complex multiplier, shift by FRAC_WIDTH, wrap on overflow
module ccmult_pipelined
  import ccmult_rr_scheduler_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  data_t i_ar,
  input  data_t i_ai,
  input  data_t i_br,
  input  data_t i_bi,
  output data_t o_pr,
  output data_t o_pi
);

  prod_t r_p_rr, r_p_ii, r_p_ri, r_p_ir;
  prod_t r_s_r, r_s_i;
  data_t r_t_r, r_t_i;
  prod_t w_sh_r, w_sh_i;
  logic  w_unused_bits;

  assign w_sh_r = r_s_r >>> FRAC_WIDTH;
  assign w_sh_i = r_s_i >>> FRAC_WIDTH;
  assign w_unused_bits = ^{w_sh_r[PROD_WIDTH-1:TOTAL_WIDTH], w_sh_i[PROD_WIDTH-1:TOTAL_WIDTH]};

  // Partial products, sums, shift/truncate, output register: one stage each.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p_rr <= '0;
      r_p_ii <= '0;
      r_p_ri <= '0;
      r_p_ir <= '0;
      r_s_r  <= '0;
      r_s_i  <= '0;
      r_t_r  <= '0;
      r_t_i  <= '0;
      o_pr   <= '0;
      o_pi   <= '0;
    end else begin
      r_p_rr <= prod_t'(i_ar) * prod_t'(i_br);
      r_p_ii <= prod_t'(i_ai) * prod_t'(i_bi);
      r_p_ri <= prod_t'(i_ar) * prod_t'(i_bi);
      r_p_ir <= prod_t'(i_ai) * prod_t'(i_br);
      r_s_r  <= r_p_rr - r_p_ii;
      r_s_i  <= r_p_ri + r_p_ir;
      r_t_r  <= w_sh_r[TOTAL_WIDTH-1:0];
      r_t_i  <= w_sh_i[TOTAL_WIDTH-1:0];
      o_pr   <= r_t_r;
      o_pi   <= r_t_i;
    end
  end

endmodule

// File: rtl/ccmult_rr_scheduler_rr_arbiter.sv
// rtl/ccmult_rr_scheduler_rr_arbiter.sv - round-robin one-hot arbiter with pointer update on accept
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_issue_en,
  input  logic [N_REQ-1:0] i_req_valid,
  output logic [N_REQ-1:0] o_grant,
  output logic [ID_W-1:0]  o_grant_id,
  output logic             o_accept
);

  logic [ID_W-1:0] r_ptr;
  logic            w_found;

  // Search above the pointer first, then wrap to indices at or below it.
  always_comb begin
    o_grant    = '0;
    o_grant_id = '0;
    w_found    = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (i_issue_en && !w_found && i_req_valid[i] && (ID_W'(i) > r_ptr)) begin
        o_grant[i] = 1'b1;
        o_grant_id = ID_W'(i);
        w_found    = 1'b1;
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (i_issue_en && !w_found && i_req_valid[i] && (ID_W'(i) <= r_ptr)) begin
        o_grant[i] = 1'b1;
        o_grant_id = ID_W'(i);
        w_found    = 1'b1;
      end
    end
  end

  assign o_accept = w_found;

  // Last granted index becomes the lowest priority; reset favours requester 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_ptr <= ID_W'(N_REQ - 1);
    else if (o_accept) r_ptr <= o_grant_id;
  end

endmodule

// File: rtl/ccmult_rr_scheduler.sv
// rtl/ccmult_rr_scheduler.sv - shares one pipelined complex multiplier among N_REQ requesters
module ccmult_rr_scheduler
  import ccmult_rr_scheduler_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ID_W     = 2,
  parameter int MULT_LAT = CCMULT_LAT,
  localparam int INF_W   = $clog2(MULT_LAT + 2)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_issue_en,
  input  logic [N_REQ-1:0]             i_req_valid,
  output logic [N_REQ-1:0]             o_req_ready,
  input  logic [N_REQ*TOTAL_WIDTH-1:0] i_req_ar,
  input  logic [N_REQ*TOTAL_WIDTH-1:0] i_req_ai,
  input  logic [N_REQ*TOTAL_WIDTH-1:0] i_req_br,
  input  logic [N_REQ*TOTAL_WIDTH-1:0] i_req_bi,
  output logic [N_REQ-1:0]             o_rsp_valid,
  output logic [ID_W-1:0]              o_rsp_id,
  output data_t                        o_rsp_pr,
  output data_t                        o_rsp_pi,
  output logic                         o_busy,
  output logic [INF_W-1:0]             o_inflight
);

  logic [N_REQ-1:0] w_grant;
  logic [ID_W-1:0]  w_grant_id;
  logic             w_accept;
  logic             w_rsp_fire;
  data_t            r_ar, r_ai, r_br, r_bi;
  logic [MULT_LAT:0] r_tag_valid;
  logic [ID_W-1:0]  r_tag_id [0:MULT_LAT];
  logic [INF_W-1:0] r_inflight;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_issue_en  (i_issue_en),
    .i_req_valid (i_req_valid),
    .o_grant     (w_grant),
    .o_grant_id  (w_grant_id),
    .o_accept    (w_accept)
  );

  assign o_req_ready = w_grant;

  // Issue registers feed the multiplier; zero when nothing is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ar <= '0;
      r_ai <= '0;
      r_br <= '0;
      r_bi <= '0;
    end else if (w_accept) begin
      r_ar <= i_req_ar[slice_lo(int'(w_grant_id)) +: TOTAL_WIDTH];
      r_ai <= i_req_ai[slice_lo(int'(w_grant_id)) +: TOTAL_WIDTH];
      r_br <= i_req_br[slice_lo(int'(w_grant_id)) +: TOTAL_WIDTH];
      r_bi <= i_req_bi[slice_lo(int'(w_grant_id)) +: TOTAL_WIDTH];
    end else begin
      r_ar <= '0;
      r_ai <= '0;
      r_br <= '0;
      r_bi <= '0;
    end
  end

  ccmult_pipelined u_mult (
    .clk   (clk),
    .rst_n (rst_n),
    .i_ar  (r_ar),
    .i_ai  (r_ai),
    .i_br  (r_br),
    .i_bi  (r_bi),
    .o_pr  (o_rsp_pr),
    .o_pi  (o_rsp_pi)
  );

  // Tag pipe: stage 0 aligns with the issue registers, stage MULT_LAT with the multiplier output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_valid <= '0;
      for (int s = 0; s <= MULT_LAT; s++) r_tag_id[s] <= '0;
    end else begin
      r_tag_valid <= {r_tag_valid[MULT_LAT-1:0], w_accept};
      r_tag_id[0] <= w_accept ? w_grant_id : '0;
      for (int s = 1; s <= MULT_LAT; s++) r_tag_id[s] <= r_tag_id[s-1];
    end
  end

  assign w_rsp_fire = r_tag_valid[MULT_LAT];

  // Occupancy: a product counts from its accept edge until its response cycle ends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_inflight <= '0;
    else begin
      case ({w_accept, w_rsp_fire})
        2'b10:   r_inflight <= r_inflight + INF_W'(1);
        2'b01:   r_inflight <= r_inflight - INF_W'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  // Decode the emerging tag into a one-hot strobe for its requester.
  always_comb begin
    o_rsp_valid = '0;
    if (w_rsp_fire) o_rsp_valid[r_tag_id[MULT_LAT]] = 1'b1;
  end

  assign o_rsp_id   = w_rsp_fire ? r_tag_id[MULT_LAT] : '0;
  assign o_inflight = r_inflight;
  assign o_busy     = (r_inflight != '0);

endmodule

// File: tb/tb_ccmult_rr_scheduler.sv
// tb/tb_ccmult_rr_scheduler.sv - randomized and directed bench with a queue-based reference model
module tb_ccmult_rr_scheduler;
  import ccmult_rr_scheduler_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TW  = TOTAL_WIDTH;

  typedef struct {
    int                    due;
    int                    id;
    logic signed [TW-1:0]  pr;
    logic signed [TW-1:0]  pi;
  } exp_t;

  logic                 clk;
  logic                 rst_n;
  logic                 issue_en;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_ready;
  logic [N*TW-1:0]      ar, ai, br, bi;
  logic [N-1:0]         rsp_valid;
  logic [IDW-1:0]       rsp_id;
  logic signed [TW-1:0] rsp_pr, rsp_pi;
  logic                 busy;
  logic [2:0]           inflight;

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   m_ptr = N - 1;
  int   peak  = 0;
  int   gcount [N];
  exp_t q [$];

  ccmult_rr_scheduler #(.N_REQ(N), .ID_W(IDW), .MULT_LAT(4)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_issue_en  (issue_en),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_ar    (ar),
    .i_req_ai    (ai),
    .i_req_br    (br),
    .i_req_bi    (bi),
    .o_rsp_valid (rsp_valid),
    .o_rsp_id    (rsp_id),
    .o_rsp_pr    (rsp_pr),
    .o_rsp_pi    (rsp_pi),
    .o_busy      (busy),
    .o_inflight  (inflight)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic longint get_op(input logic [N*TW-1:0] v, input int i);
    logic signed [TW-1:0] x;
    x = v[i*TW +: TW];
    return longint'(x);
  endfunction

  function automatic logic signed [TW-1:0] trunc_shift(input longint v);
    longint s;
    s = v >>> FRAC_WIDTH;
    return s[TW-1:0];
  endfunction

  task automatic set_op(input int i, input int a_r, input int a_i, input int b_r, input int b_i);
    ar[i*TW +: TW] = a_r[TW-1:0];
    ai[i*TW +: TW] = a_i[TW-1:0];
    br[i*TW +: TW] = b_r[TW-1:0];
    bi[i*TW +: TW] = b_i[TW-1:0];
  endtask

  task automatic rand_ops();
    ar = {$urandom(), $urandom()};
    ai = {$urandom(), $urandom()};
    br = {$urandom(), $urandom()};
    bi = {$urandom(), $urandom()};
  endtask

  // One clock of checking against the model, then advance past the next rising edge.
  task automatic step();
    logic [N-1:0] eg;
    int           gid;
    int           idx;
    exp_t         e;
    longint       xr, xi, yr, yi;
    @(negedge clk);
    eg  = '0;
    gid = -1;
    if (issue_en) begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_ptr + k) % N;
        if (gid < 0 && req_valid[idx]) gid = idx;
      end
    end
    if (gid >= 0) eg[gid] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(eg));
    chk("inflight", 32'(inflight), q.size());
    chk("busy", 32'(busy), 32'(q.size() != 0));
    if (int'(inflight) > peak) peak = int'(inflight);
    if (q.size() > 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk("rsp_valid", 32'(rsp_valid), 1 << e.id);
      chk("rsp_id", 32'(rsp_id), e.id);
      chk("rsp_pr", 32'(rsp_pr), 32'(e.pr));
      chk("rsp_pi", 32'(rsp_pi), 32'(e.pi));
    end else begin
      chk("rsp_valid_idle", 32'(rsp_valid), 0);
      chk("rsp_id_idle", 32'(rsp_id), 0);
    end
    if (gid >= 0) begin
      xr = get_op(ar, gid);
      xi = get_op(ai, gid);
      yr = get_op(br, gid);
      yi = get_op(bi, gid);
      e.due = cyc + 5;
      e.id  = gid;
      e.pr  = trunc_shift(xr * yr - xi * yi);
      e.pi  = trunc_shift(xr * yi + xi * yr);
      q.push_back(e);
      m_ptr = gid;
      gcount[gid]++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_id"}, 32'(rsp_id), 0);
    chk({tag, "_rsp_pr"}, 32'(rsp_pr), 0);
    chk({tag, "_rsp_pi"}, 32'(rsp_pi), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_inflight"}, 32'(inflight), 0);
  endtask

  initial begin
    rst_n     = 1'b0;
    issue_en  = 1'b0;
    req_valid = '0;
    ar = '0; ai = '0; br = '0; bi = '0;
    for (int i = 0; i < N; i++) gcount[i] = 0;

    // Reset state, and requester 0 holds first priority out of reset.
    repeat (2) @(posedge clk);
    #1;
    chk_zero_outputs("reset");
    chk("reset_ready_off", 32'(req_ready), 0);
    issue_en  = 1'b1;
    req_valid = '1;
    #1;
    chk("reset_first_prio", 32'(req_ready), 32'h1);
    req_valid = '0;
    rst_n     = 1'b1;

    // Single request: (1.0)(0.5+0.5j) = 0.5+0.5j on requester 0.
    set_op(0, 4096, 0, 2048, 2048);
    req_valid = 4'b0001;
    step();
    req_valid = '0;
    repeat (7) step();

    // All requesters continuously valid: rotating grants, gap-free returns, peak occupancy.
    peak      = 0;
    req_valid = 4'b1111;
    repeat (8) begin
      rand_ops();
      step();
    end
    req_valid = '0;
    repeat (6) step();
    chk("peak_inflight", peak, 5);

    // Complex products on requester 2.
    req_valid = 4'b0100;
    set_op(2, 2048, 2048, 2048, -2048);
    step();
    set_op(2, 0, 4096, 0, 4096);
    step();
    req_valid = '0;
    repeat (6) step();

    // Drain: issue_en drops with three products in flight.
    req_valid = 4'b1111;
    repeat (3) begin
      rand_ops();
      step();
    end
    issue_en = 1'b0;
    repeat (8) step();
    req_valid = '0;
    issue_en  = 1'b1;
    step();

    // Asynchronous reset two cycles after three accepts discards everything in flight.
    req_valid = 4'b1111;
    repeat (3) begin
      rand_ops();
      step();
    end
    req_valid = '0;
    repeat (2) step();
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("async_reset");
    q.delete();
    m_ptr = N - 1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (10) step();
    req_valid = 4'b1111;
    rand_ops();
    step();
    req_valid = '0;
    repeat (6) step();

    // Pointer wrap and fairness between requesters 3 and 0.
    for (int i = 0; i < N; i++) gcount[i] = 0;
    req_valid = 4'b1001;
    repeat (6) begin
      rand_ops();
      step();
    end
    req_valid = '0;
    repeat (6) step();
    chk("fair_req0", gcount[0], 3);
    chk("fair_req3", gcount[3], 3);

    // Randomized traffic with occasional drain windows.
    repeat (300) begin
      rand_ops();
      req_valid = 4'($urandom());
      issue_en  = ($urandom_range(0, 4) != 0);
      step();
    end
    req_valid = '0;
    issue_en  = 1'b1;
    repeat (8) step();
    chk("final_queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
